// File: rtl/sram_responder.sv
// sram_responder
//
// Memory-side responder for the SLC-3 external SRAM bus. It decodes the
// active-low CE/UB/LB/OE/WE strobes and the word address, keeps the backing
// store in on-chip RAM and returns read data through a registered
// Data_to_bus / Data_oe pair after READ_LAT clock edges. It also keeps debug
// counters and a sticky strobe-conflict flag.
//
// Parameters
//   ADDR_W   : memory depth is 2**ADDR_W words; ADDR[19:ADDR_W] alias
//   READ_LAT : edges from a sampled read request to valid data (1..7)
//
// Ports
//   Clk, Reset         : clock, asynchronous active-low reset
//   CE/UB/LB/OE/WE     : active-low chip, byte, output and write enables
//   ADDR               : 20-bit word address
//   Data_from_bus      : write data from the bus
//   Data_to_bus        : registered read data
//   Data_oe            : high while the responder drives the bus
//   err_conflict       : sticky, set when CE, OE and WE are sampled low together
//   rd_count, wr_count : saturating completed-read / write-access counters
//   ld_valid, ld_last, ld_data, ld_ready, ld_done
//                      : word loader, present only with SRAM_RESP_LOADER_EN
//
// Build option
//   SRAM_RESP_LOADER_EN : adds the loader ports and the LOAD state; the block
//                         then leaves reset loading memory from word 0.

module sram_responder #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned READ_LAT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        CE,
   input  logic        UB,
   input  logic        LB,
   input  logic        OE,
   input  logic        WE,
   input  logic [19:0] ADDR,
   input  logic [15:0] Data_from_bus,
`ifdef SRAM_RESP_LOADER_EN
   input  logic        ld_valid,
   input  logic        ld_last,
   input  logic [15:0] ld_data,
   output logic        ld_ready,
   output logic        ld_done,
`endif
   output logic [15:0] Data_to_bus,
   output logic        Data_oe,
   output logic        err_conflict,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int unsigned Depth   = 1 << ADDR_W;
   // Counter is loaded with READ_LAT-1 on the request edge, so RD_DRIVE is
   // entered exactly READ_LAT edges after the request.
   localparam logic [2:0]  LatInit = 3'(READ_LAT - 1);

   typedef enum logic [2:0] {
`ifdef SRAM_RESP_LOADER_EN
      StLoad    = 3'd0,
`endif
      StIdle    = 3'd1,
      StRdWait  = 3'd2,
      StRdDrive = 3'd3,
      StWrite   = 3'd4
   } state_e;

`ifdef SRAM_RESP_LOADER_EN
   localparam state_e StReset = StLoad;
`else
   localparam state_e StReset = StIdle;
`endif

   state_e        state_q, state_d;
   logic [19:0]   addr_q, addr_d;
   logic [2:0]    lat_q, lat_d;
   logic          oe_q, oe_d;
   logic [15:0]   dout_q, dout_d;
   logic          err_q, err_d;
   logic [15:0]   rdc_q, rdc_d;
   logic [15:0]   wrc_q, wrc_d;
`ifdef SRAM_RESP_LOADER_EN
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ld_ready_q, ld_ready_d;
   logic              ld_done_q, ld_done_d;
`endif

   logic [15:0]       mem [Depth];
   logic              mem_we;
   logic [1:0]        mem_be;
   logic [ADDR_W-1:0] mem_widx;
   logic [15:0]       mem_wdata;
   logic [15:0]       rd_word;

   logic bus_wr;
   logic bus_rd;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A deasserted byte enable forces that byte of the returned word to zero.
   function automatic logic [15:0] mask_rd(input logic [15:0] w, input logic ub,
                                           input logic lb);
      return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
   endfunction

   assign bus_wr  = !CE && !WE;
   assign bus_rd  = !CE && !OE && WE;
   assign rd_word = mem[addr_q[ADDR_W-1:0]];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lat_d     = lat_q;
      oe_d      = oe_q;
      dout_d    = dout_q;
      err_d     = err_q;
      rdc_d     = rdc_q;
      wrc_d     = wrc_q;
      mem_we    = 1'b0;
      mem_be    = 2'b00;
      mem_widx  = ADDR[ADDR_W-1:0];
      mem_wdata = Data_from_bus;
`ifdef SRAM_RESP_LOADER_EN
      ptr_d      = ptr_q;
      ld_ready_d = ld_ready_q;
      ld_done_d  = ld_done_q;

      if (state_q == StLoad) begin
         // Bus strobes are ignored until the image is loaded.
         oe_d = 1'b0;
         if (ld_valid) begin
            mem_we    = 1'b1;
            mem_be    = 2'b11;
            mem_widx  = ptr_q;
            mem_wdata = ld_data;
            ptr_d     = ptr_q + 1'b1;
            if (ld_last) begin
               state_d    = StIdle;
               ld_ready_d = 1'b0;
               ld_done_d  = 1'b1;
            end
         end
      end else
`endif
      if (bus_wr) begin
         // A write strobe wins in every bus state, including a CE/OE/WE
         // conflict; the bus is released on the same edge.
         mem_we  = 1'b1;
         mem_be  = {!UB, !LB};
         state_d = StWrite;
         oe_d    = 1'b0;
         if (!OE) begin
            err_d = 1'b1;
         end
         if (state_q != StWrite) begin
            wrc_d = sat_inc(wrc_q);
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (bus_rd) begin
                  state_d = StRdWait;
                  addr_d  = ADDR;
                  lat_d   = LatInit;
                  oe_d    = 1'b0;
               end
            end
            StRdWait: begin
               if (CE || OE) begin
                  state_d = StIdle;
                  oe_d    = 1'b0;
               end else if (ADDR != addr_q) begin
                  // New address restarts the full latency.
                  addr_d = ADDR;
                  lat_d  = LatInit;
               end else if (lat_q == 3'd0) begin
                  state_d = StRdDrive;
                  oe_d    = 1'b1;
                  dout_d  = mask_rd(rd_word, UB, LB);
                  rdc_d   = sat_inc(rdc_q);
               end else begin
                  lat_d = lat_q - 3'd1;
               end
            end
            StRdDrive: begin
               if (CE || OE) begin
                  state_d = StIdle;
                  oe_d    = 1'b0;
               end else if (ADDR != addr_q) begin
                  state_d = StRdWait;
                  addr_d  = ADDR;
                  lat_d   = LatInit;
                  oe_d    = 1'b0;
               end else begin
                  dout_d = mask_rd(rd_word, UB, LB);
               end
            end
            StWrite: begin
               // No write strobe this edge: CE or WE has been released.
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StReset;
         addr_q  <= 20'h00000;
         lat_q   <= 3'd0;
         oe_q    <= 1'b0;
         dout_q  <= 16'h0000;
         err_q   <= 1'b0;
         rdc_q   <= 16'h0000;
         wrc_q   <= 16'h0000;
`ifdef SRAM_RESP_LOADER_EN
         ptr_q      <= '0;
         ld_ready_q <= 1'b1;
         ld_done_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
         rdc_q   <= rdc_d;
         wrc_q   <= wrc_d;
`ifdef SRAM_RESP_LOADER_EN
         ptr_q      <= ptr_d;
         ld_ready_q <= ld_ready_d;
         ld_done_q  <= ld_done_d;
`endif
      end
   end

   // Memory is never cleared. Reset gates the write so a cycle that is in
   // flight while Reset is low is not committed.
   always_ff @(posedge Clk) begin
      if (mem_we && Reset) begin
         if (mem_be[1]) begin
            mem[mem_widx][15:8] <= mem_wdata[15:8];
         end
         if (mem_be[0]) begin
            mem[mem_widx][7:0] <= mem_wdata[7:0];
         end
      end
   end

   assign Data_to_bus  = dout_q;
   assign Data_oe      = oe_q;
   assign err_conflict = err_q;
   assign rd_count     = rdc_q;
   assign wr_count     = wrc_q;
`ifdef SRAM_RESP_LOADER_EN
   assign ld_ready     = ld_ready_q;
   assign ld_done      = ld_done_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
`timescale 1ns/1ps
module tb_sram_responder;

   localparam int unsigned LAT  = 2;
   localparam int unsigned NIDX = 32;

   logic        clk;
   logic        rst_n;
   logic        ce, ub, lb, oe, we;
   logic [19:0] addr;
   logic [15:0] din;
   logic [15:0] dout;
   logic        doe;
   logic        err;
   logic [15:0] rdc, wrc;
`ifdef SRAM_RESP_LOADER_EN
   logic        ld_valid, ld_last, ld_ready, ld_done;
   logic [15:0] ld_data;
`endif

   int n_total = 0;
   int n_pass  = 0;

   // Reference: plain word array plus expected access counts.
   logic [15:0] mdl [1024];
   int exp_rd = 0;
   int exp_wr = 0;

   sram_responder #(.ADDR_W(10), .READ_LAT(LAT)) dut (
      .Clk           (clk),
      .Reset         (rst_n),
      .CE            (ce),
      .UB            (ub),
      .LB            (lb),
      .OE            (oe),
      .WE            (we),
      .ADDR          (addr),
      .Data_from_bus (din),
`ifdef SRAM_RESP_LOADER_EN
      .ld_valid      (ld_valid),
      .ld_last       (ld_last),
      .ld_data       (ld_data),
      .ld_ready      (ld_ready),
      .ld_done       (ld_done),
`endif
      .Data_to_bus   (dout),
      .Data_oe       (doe),
      .err_conflict  (err),
      .rd_count      (rdc),
      .wr_count      (wrc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ce_v, input logic oe_v, input logic we_v,
                        input logic ub_v, input logic lb_v,
                        input logic [19:0] a, input logic [15:0] d);
      ce = ce_v; oe = oe_v; we = we_v; ub = ub_v; lb = lb_v; addr = a; din = d;
   endtask

   task automatic bus_idle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00000, 16'h0000);
   endtask

   task automatic mdl_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub_v, input logic lb_v);
      int i;
      i = int'(a % 1024);
      if (!ub_v) mdl[i] = (mdl[i] % 256) + (d / 256) * 256;
      if (!lb_v) mdl[i] = (mdl[i] / 256) * 256 + (d % 256);
   endtask

   function automatic logic [15:0] mdl_read(input logic [19:0] a, input logic ub_v,
                                            input logic lb_v);
      logic [15:0] w;
      w = mdl[int'(a % 1024)];
      if (ub_v) w = w % 256;
      if (lb_v) w = (w / 256) * 256;
      return w;
   endfunction

   task automatic count_wr();
      if (exp_wr < 65535) exp_wr++;
   endtask

   task automatic count_rd();
      if (exp_rd < 65535) exp_rd++;
   endtask

   task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                           input logic ub_v, input logic lb_v);
      drive(1'b0, 1'b1, 1'b0, ub_v, lb_v, a, d);
      tick();
      mdl_write(a, d, ub_v, lb_v);
      count_wr();
      bus_idle();
      tick();
   endtask

   task automatic do_read(input string nm, input logic [19:0] a, input logic ub_v,
                          input logic lb_v, input logic [15:0] exp_d);
      int lat;
      drive(1'b0, 1'b0, 1'b1, ub_v, lb_v, a, 16'h0000);
      tick();
      lat = 0;
      while (doe !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      chk({nm, " latency"}, lat, LAT);
      chk({nm, " data"}, dout, exp_d);
      count_rd();
      bus_idle();
      tick();
      chk({nm, " release"}, doe, 1'b0);
   endtask

   typedef struct {
      bit          do_wr;
      logic [19:0] a;
      logic [15:0] wd;
      logic        wub, wlb, rub, rlb;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [19:0] a;
      logic [15:0] d;
      logic        u, l;
      int          n, lat;

      vecs[0] = '{1'b1, 20'h00005, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
      vecs[1] = '{1'b1, 20'h00005, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h12CD};
      vecs[2] = '{1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1200};
      vecs[3] = '{1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00CD};
      vecs[4] = '{1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
      vecs[5] = '{1'b1, 20'h00009, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF};
      vecs[6] = '{1'b1, 20'h00009, 16'h1200, 1'b0, 1'b1, 1'b0, 1'b0, 16'h12FF};
      vecs[7] = '{1'b1, 20'hFFC09, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234};
      vecs[8] = '{1'b1, 20'h00006, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0042};

      rst_n = 1'b0;
      bus_idle();
`ifdef SRAM_RESP_LOADER_EN
      ld_valid = 1'b0; ld_last = 1'b0; ld_data = 16'h0000;
`endif
      tick();
      tick();
      chk("reset Data_oe", doe, 1'b0);
      chk("reset Data_to_bus", dout, 16'h0000);
      chk("reset err_conflict", err, 1'b0);
      chk("reset rd_count", rdc, 16'h0000);
      chk("reset wr_count", wrc, 16'h0000);
`ifdef SRAM_RESP_LOADER_EN
      chk("reset ld_ready", ld_ready, 1'b1);
      chk("reset ld_done", ld_done, 1'b0);
`endif
      rst_n = 1'b1;
      tick();

`ifdef SRAM_RESP_LOADER_EN
      // Strobes driven during LOAD must be ignored.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 16'hFFFF);
      ld_valid = 1'b1; ld_data = 16'h1111; tick();
      ld_data = 16'h2222; tick();
      ld_data = 16'h3333; ld_last = 1'b1; tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      bus_idle();
      tick();
      chk("load ld_done", ld_done, 1'b1);
      chk("load ld_ready", ld_ready, 1'b0);
      chk("load wr_count", wrc, 16'h0000);
      mdl[0] = 16'h1111; mdl[1] = 16'h2222; mdl[2] = 16'h3333;
      do_read("load word0", 20'h00000, 1'b0, 1'b0, 16'h1111);
      do_read("load word1", 20'h00001, 1'b0, 1'b0, 16'h2222);
      do_read("load word2", 20'h00002, 1'b0, 1'b0, 16'h3333);
`endif

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_wr) do_write(vecs[i].a, vecs[i].wd, vecs[i].wub, vecs[i].wlb);
         do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].rub, vecs[i].rlb, vecs[i].exp);
         chk($sformatf("vec%0d wr_count", i), wrc, exp_wr);
         chk($sformatf("vec%0d rd_count", i), rdc, exp_rd);
      end

      // Address switch during RD_WAIT restarts the latency.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00005, 16'h0000);
      tick();
      chk("switch wait oe0", doe, 1'b0);
      addr = 20'h00006;
      tick();
      chk("switch wait oe1", doe, 1'b0);
      tick();
      chk("switch wait oe2", doe, 1'b0);
      tick();
      chk("switch wait oe3", doe, 1'b1);
      chk("switch wait data", dout, 16'h0042);
      count_rd();
      // Address switch during RD_DRIVE drops the bus and restarts.
      addr = 20'h00005;
      tick();
      chk("switch drive oe0", doe, 1'b0);
      tick();
      chk("switch drive oe1", doe, 1'b0);
      tick();
      chk("switch drive oe2", doe, 1'b1);
      chk("switch drive data", dout, 16'h12CD);
      count_rd();
      ub = 1'b1;
      tick();
      chk("drive follows UB", dout, 16'h00CD);
      bus_idle();
      tick();
      chk("switch release", doe, 1'b0);
      chk("switch rd_count", rdc, exp_rd);

      // CE/OE/WE conflict: write proceeds, bus stays released, flag sticks.
      chk("pre-conflict err", err, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00007, 16'h5555);
      tick();
      mdl_write(20'h00007, 16'h5555, 1'b0, 1'b0);
      count_wr();
      chk("conflict oe", doe, 1'b0);
      chk("conflict err", err, 1'b1);
      tick();
      chk("conflict hold oe", doe, 1'b0);
      bus_idle();
      tick();
      chk("conflict sticky", err, 1'b1);
      do_read("conflict readback", 20'h00007, 1'b0, 1'b0, 16'h5555);
      chk("conflict wr_count", wrc, exp_wr);

      // Randomised traffic against the reference array.
      for (int i = 0; i < NIDX; i++) do_write(20'(i), 16'($urandom), 1'b0, 1'b0);
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 1) == 0) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
               a = {10'($urandom), 10'($urandom_range(0, NIDX - 1))};
               d = 16'($urandom);
               u = 1'($urandom);
               l = 1'($urandom);
               drive(1'b0, 1'b1, 1'b0, u, l, a, d);
               tick();
               mdl_write(a, d, u, l);
            end
            count_wr();
            bus_idle();
            tick();
         end else begin
            a = {10'($urandom), 10'($urandom_range(0, NIDX - 1))};
            u = 1'($urandom);
            l = 1'($urandom);
            do_read($sformatf("rand%0d", t), a, u, l, mdl_read(a, u, l));
         end
      end
      chk("rand wr_count", wrc, exp_wr);
      chk("rand rd_count", rdc, exp_rd);

      // Reset while driving: outputs clear at once, memory survives.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00006, 16'h0000);
      lat = 0;
      while (doe !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      chk("pre-reset drive", doe, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async reset oe", doe, 1'b0);
      chk("async reset data", dout, 16'h0000);
      chk("async reset rd_count", rdc, 16'h0000);
      chk("async reset wr_count", wrc, 16'h0000);
      chk("async reset err", err, 1'b0);
      bus_idle();
      tick();
      rst_n = 1'b1;
      exp_rd = 0;
      exp_wr = 0;
      tick();
`ifdef SRAM_RESP_LOADER_EN
      ld_valid = 1'b1; ld_last = 1'b1; ld_data = mdl[0];
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("reload ld_done", ld_done, 1'b1);
`endif
      chk("post-reset rd_count", rdc, 16'h0000);
      chk("post-reset wr_count", wrc, 16'h0000);
      do_read("post-reset mem", 20'h00006, 1'b0, 1'b0, mdl_read(20'h00006, 1'b0, 1'b0));
      chk("post-reset rd_count 1", rdc, exp_rd);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable memory-side responder for the SLC-3 external SRAM interface. It answers the active-low CE/UB/LB/OE/WE strobes and 20-bit address driven by the CPU's memory subsystem, holds the backing store in on-chip RAM, and returns read data through a tristate-enable pair after a fixed read latency. It replaces the off-chip 1Mx16 SRAM in simulation and in on-chip builds, and adds access counters and a strobe-conflict flag for debug.

## Interface
- ADDR_W, 10, memory depth is 2^ADDR_W 16-bit words; ADDR[19:ADDR_W] ignored (aliasing)
- READ_LAT, 2, cycles from sampled read request to valid data; legal range 1..7
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- CE, UB, LB, OE, WE  in  1 each  active-low chip enable, upper/lower byte enable, output enable, write enable
- ADDR  in  20  word address
- Data_from_bus  in  16  write data from the tristate read side
- Data_to_bus  out  16  read data toward the tristate write side
- Data_oe  out  1  high = responder drives the bus
- err_conflict  out  1  sticky; CE, OE and WE sampled low together
- rd_count  out  16  completed read accesses, saturating
- wr_count  out  16  write accesses, saturating
- ld_valid, ld_last  in  1 each  loader strobe / final word (SRAM_RESP_LOADER_EN only)
- ld_data  in  16  loader word (SRAM_RESP_LOADER_EN only)
- ld_ready, ld_done  out  1 each  loader accept / load complete (SRAM_RESP_LOADER_EN only)

## Operation
- Reset values: Data_oe 0, Data_to_bus 16'h0000, err_conflict 0, rd_count 0, wr_count 0, ld_done 0, ld_ready 1 if loader compiled in, else no loader ports. Memory contents are not cleared.
- States: LOAD (loader only), IDLE, RD_WAIT, RD_DRIVE, WRITE. Reset enters LOAD with the macro, IDLE without.
- Index = ADDR[ADDR_W-1:0]. Strobes and ADDR are sampled on each rising edge.
- IDLE: CE=0, WE=0 -> WRITE. CE=0, OE=0, WE=1 -> RD_WAIT; latch index; start latency counter at READ_LAT-1.
- RD_WAIT: counter decrements each cycle. At 0 -> RD_DRIVE, Data_oe=1. Data_to_bus = mem[index], with the upper byte forced to 8'h00 when UB=1 and the lower byte forced to 8'h00 when LB=1. rd_count increments once on entry.
- RD_DRIVE: data follows UB/LB each cycle. An ADDR change while CE=0 and OE=0 -> RD_WAIT with a fresh latency and Data_oe=0. CE=1 or OE=1 -> IDLE, Data_oe=0.
- Any read state, WE sampled 0 with CE=0 -> WRITE; Data_oe=0 that edge.
- WRITE: every edge with CE=0 and WE=0 writes Data_from_bus[15:8] when UB=0 and [7:0] when LB=0 to mem[index of that cycle]. wr_count increments once on entry, not per cycle. CE=1 or WE=1 -> IDLE.
- Conflict: CE=0, OE=0, WE=0 -> write proceeds, Data_oe stays 0, err_conflict=1 until reset.
- Counters saturate at 16'hFFFF.
- LOAD: ld_ready=1. Each ld_valid cycle writes ld_data to mem[load_ptr]; load_ptr starts at 0 and wraps at 2^ADDR_W. ld_valid with ld_last -> IDLE, ld_ready=0, ld_done=1 (sticky). Bus strobes are ignored and Data_oe=0 while in LOAD.

## Timing
- Read: request sampled at edge N -> Data_oe=1 and data valid after edge N+READ_LAT.
- Deassert: Data_oe falls on the first edge that samples CE=1, OE=1 or WE=0. It never falls combinationally, except on async Reset.
- Write: data is stored at the same edge that samples WE=0. A read of that index started at the next edge returns the new data.
- Reset mid-access: Data_oe and all outputs go to reset values immediately. An in-flight write cycle is not committed.

## Configuration
- SRAM_RESP_LOADER_EN defined: loader ports and the LOAD state exist, and the block comes out of reset loading from word 0.
- SRAM_RESP_LOADER_EN not defined: loader ports and the LOAD state are absent, reset enters IDLE, and memory starts uninitialised in simulation (X).

## Test plan
- Write 16'h1234 to ADDR 5 with UB=LB=0, then read ADDR 5 with READ_LAT=2 -> Data_oe=1 exactly 2 edges after the request; Data_to_bus=16'h1234; wr_count=1, rd_count=1.
- Write 16'hABCD to ADDR 5 with UB=1, LB=0 -> read returns 16'h12CD. Read with LB=1 -> 16'h1200.
- Start a read of ADDR 5, then switch ADDR to 6 (holding 16'h0042) in the RD_WAIT cycle -> Data_oe held 0 for a full READ_LAT from the switch, then 16'h0042.
- CE=OE=WE=0 with data 16'h5555 at ADDR 7 -> mem[7]=16'h5555, Data_oe=0, err_conflict=1 and it stays 1 after the strobes release.
- Assert Reset low during RD_DRIVE -> Data_oe=0 at once; counters 0 after release.
- Loader build: stream 16'h1111, 16'h2222, then 16'h3333 with ld_last -> ld_done=1; reads of ADDR 0..2 return those values; strobes during LOAD are ignored.
